// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front end.
//   PIX_W  pixel width (two's complement)
//   IMG_W  pixels per row, IMG_H rows per frame
//   K      convolution window size
package cnn_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned IMG_W = 28;
  localparam int unsigned IMG_H = 28;
  localparam int unsigned K     = 5;

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef enum logic {FILL, STREAM} lb_state_t;

endpackage

// File: rtl/line_delay.sv
// Enable-gated delay line built on a circular RAM.
//   clk, rst_n  clock, asynchronous active-low reset (pointer only)
//   en          advance the line by one entry
//   din         value written at the current pointer
//   dout        value written DEPTH enabled cycles ago
// Read and write share one pointer, so dout is the old entry that din replaces.
// The RAM itself is not reset; its contents only matter once a full line has passed.
module line_delay #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr_q;

  assign dout = mem[ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/conv_window_linebuf5x5.sv
// Streaming 5x5 window generator for a 28x28 row-major signed pixel stream.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              in_data carries a pixel this cycle (always accepted)
//   in_sof                with in_valid: this pixel is (0,0) of a new frame
//   in_data               signed pixel
//   data_out_0..24        window, data_out_{5i+j} = pixel(r-4+i, c-4+j)
//   valid_out_buf         one-cycle pulse: window is complete (no padding)
//   frame_done            one-cycle pulse with the last window of a frame
module conv_window_linebuf5x5
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_data,
  output logic [PIX_W-1:0] data_out_0,
  output logic [PIX_W-1:0] data_out_1,
  output logic [PIX_W-1:0] data_out_2,
  output logic [PIX_W-1:0] data_out_3,
  output logic [PIX_W-1:0] data_out_4,
  output logic [PIX_W-1:0] data_out_5,
  output logic [PIX_W-1:0] data_out_6,
  output logic [PIX_W-1:0] data_out_7,
  output logic [PIX_W-1:0] data_out_8,
  output logic [PIX_W-1:0] data_out_9,
  output logic [PIX_W-1:0] data_out_10,
  output logic [PIX_W-1:0] data_out_11,
  output logic [PIX_W-1:0] data_out_12,
  output logic [PIX_W-1:0] data_out_13,
  output logic [PIX_W-1:0] data_out_14,
  output logic [PIX_W-1:0] data_out_15,
  output logic [PIX_W-1:0] data_out_16,
  output logic [PIX_W-1:0] data_out_17,
  output logic [PIX_W-1:0] data_out_18,
  output logic [PIX_W-1:0] data_out_19,
  output logic [PIX_W-1:0] data_out_20,
  output logic [PIX_W-1:0] data_out_21,
  output logic [PIX_W-1:0] data_out_22,
  output logic [PIX_W-1:0] data_out_23,
  output logic [PIX_W-1:0] data_out_24,
  output logic             valid_out_buf,
  output logic             frame_done
);

  if (K != 5) begin : gen_bad_k
    $error("conv_window_linebuf5x5 only supports K == 5");
  end

  logic [COL_W-1:0] col_q, col_d, eff_col;
  logic [ROW_W-1:0] row_q, row_d, eff_row;
  lb_state_t        state_q, state_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             last_pix;

  logic [PIX_W-1:0] lb_in  [K-1];
  logic [PIX_W-1:0] lb_out [K-1];
  pixel_t           new_col [K];
  pixel_t           win_q [K][K];

  // Line buffers: tap k carries the pixel from row r-1-k at the current column.
  assign lb_in[0] = in_data;

  for (genvar k = 0; k < K - 1; k++) begin : gen_lb
    if (k > 0) begin : gen_cascade
      assign lb_in[k] = lb_out[k-1];
    end
    line_delay #(
      .DEPTH(IMG_W),
      .W    (PIX_W)
    ) u_line_delay (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (in_valid),
      .din  (lb_in[k]),
      .dout (lb_out[k])
    );
  end

  // Newest pixel enters the bottom row; oldest tap feeds the top row.
  always_comb begin
    new_col[K-1] = pixel_t'(in_data);
    for (int i = 0; i < K - 1; i++) begin
      new_col[i] = pixel_t'(lb_out[K-2-i]);
    end
  end

  always_comb begin
    // in_sof forces this pixel to (0,0) regardless of where the counters were.
    eff_col  = in_sof ? '0 : col_q;
    eff_row  = in_sof ? '0 : row_q;
    last_pix = (eff_col == COL_W'(IMG_W - 1)) && (eff_row == ROW_W'(IMG_H - 1));

    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (in_valid) begin
      if (eff_col == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (eff_row == ROW_W'(IMG_H - 1)) ? '0 : eff_row + ROW_W'(1);
      end else begin
        col_d = eff_col + COL_W'(1);
        row_d = eff_row;
      end

      unique case (state_q)
        FILL: begin
          if ((eff_row == ROW_W'(K - 1)) && (eff_col == '0)) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (in_sof || last_pix) begin
            state_d = FILL;
          end
        end
      endcase

      // Row-wrap windows (col < K-1) are shifted in but never flagged.
      valid_d = (state_q == STREAM) && !in_sof && (eff_col >= COL_W'(K - 1));
      done_d  = valid_d && last_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FILL;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (in_valid) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_q[i][j] <= win_q[i][j+1];
        end
        win_q[i][K-1] <= new_col[i];
      end
    end
  end

  assign valid_out_buf = valid_q;
  assign frame_done    = done_q;

  assign data_out_0  = win_q[0][0];
  assign data_out_1  = win_q[0][1];
  assign data_out_2  = win_q[0][2];
  assign data_out_3  = win_q[0][3];
  assign data_out_4  = win_q[0][4];
  assign data_out_5  = win_q[1][0];
  assign data_out_6  = win_q[1][1];
  assign data_out_7  = win_q[1][2];
  assign data_out_8  = win_q[1][3];
  assign data_out_9  = win_q[1][4];
  assign data_out_10 = win_q[2][0];
  assign data_out_11 = win_q[2][1];
  assign data_out_12 = win_q[2][2];
  assign data_out_13 = win_q[2][3];
  assign data_out_14 = win_q[2][4];
  assign data_out_15 = win_q[3][0];
  assign data_out_16 = win_q[3][1];
  assign data_out_17 = win_q[3][2];
  assign data_out_18 = win_q[3][3];
  assign data_out_19 = win_q[3][4];
  assign data_out_20 = win_q[4][0];
  assign data_out_21 = win_q[4][1];
  assign data_out_22 = win_q[4][2];
  assign data_out_23 = win_q[4][3];
  assign data_out_24 = win_q[4][4];

endmodule

// File: tb/tb_conv_window_linebuf5x5.sv
module tb_conv_window_linebuf5x5;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic [7:0] dout [25];
  logic       valid_out_buf;
  logic       frame_done;

  int total;
  int bad;

  // Reference model state: image of accepted pixels indexed by frame position.
  logic [7:0]   img [28][28];
  int           mr, mc;
  int           acc_cnt, pulse_cnt, tot_pulse, fd_cnt, first_at;
  logic [7:0]   first0, first12, first24, last24;
  logic [199:0] last_flat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_window_linebuf5x5 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_data      (in_data),
    .data_out_0   (dout[0]),
    .data_out_1   (dout[1]),
    .data_out_2   (dout[2]),
    .data_out_3   (dout[3]),
    .data_out_4   (dout[4]),
    .data_out_5   (dout[5]),
    .data_out_6   (dout[6]),
    .data_out_7   (dout[7]),
    .data_out_8   (dout[8]),
    .data_out_9   (dout[9]),
    .data_out_10  (dout[10]),
    .data_out_11  (dout[11]),
    .data_out_12  (dout[12]),
    .data_out_13  (dout[13]),
    .data_out_14  (dout[14]),
    .data_out_15  (dout[15]),
    .data_out_16  (dout[16]),
    .data_out_17  (dout[17]),
    .data_out_18  (dout[18]),
    .data_out_19  (dout[19]),
    .data_out_20  (dout[20]),
    .data_out_21  (dout[21]),
    .data_out_22  (dout[22]),
    .data_out_23  (dout[23]),
    .data_out_24  (dout[24]),
    .valid_out_buf(valid_out_buf),
    .frame_done   (frame_done)
  );

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [199:0] pack();
    logic [199:0] f;
    for (int k = 0; k < 25; k++) f[k*8 +: 8] = dout[k];
    return f;
  endfunction

  // Called just after a falling edge: drive, let the rising edge accept, check at the next fall.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    logic [199:0] flat, expw;
    logic         ev, efd;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    ev   = 1'b0;
    efd  = 1'b0;
    expw = '0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
        pulse_cnt = 0;
        acc_cnt = 0;
      end
      acc_cnt++;
      img[mr][mc] = d;
      if (mr >= 4 && mc >= 4) begin
        ev = 1'b1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            expw[(5*i+j)*8 +: 8] = img[mr-4+i][mc-4+j];
      end
      efd = ev && mr == 27 && mc == 27;
      if (mc == 27) begin
        mc = 0;
        mr = (mr == 27) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    @(negedge clk);
    flat = pack();
    chk("pulse", 200'({valid_out_buf, frame_done}), 200'({ev, efd}));
    if (ev) chk("win", flat, expw);
    else if (!v) chk("hold", flat, last_flat);
    if (valid_out_buf) begin
      if (pulse_cnt == 0) begin
        first0   = dout[0];
        first12  = dout[12];
        first24  = dout[24];
        first_at = acc_cnt;
      end
      pulse_cnt++;
      tot_pulse++;
    end
    if (frame_done) begin
      fd_cnt++;
      last24 = dout[24];
    end
    last_flat = flat;
  endtask

  task automatic send_pixels(input logic [7:0] orv, input int n, input bit duty);
    for (int idx = 0; idx < n; idx++) begin
      if (duty) begin
        while ($urandom_range(1, 0) == 0) step(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
      end
      step(1'b1, idx == 0, orv | 8'(idx & 127));
    end
  endtask

  task automatic check_frame1(input string tag);
    chk({tag, "_npulse"}, 200'(pulse_cnt), 200'(576));
    chk({tag, "_ndone"}, 200'(fd_cnt), 200'(1));
    chk({tag, "_first_at"}, 200'(first_at), 200'(117));
    chk({tag, "_f_d0"}, 200'(first0), 200'(0));
    chk({tag, "_f_d12"}, 200'(first12), 200'(58));
    chk({tag, "_f_d24"}, 200'(first24), 200'(116));
    chk({tag, "_last_d24"}, 200'(last24), 200'(15));
  endtask

  initial begin
    total = 0;
    bad = 0;
    mr = 0;
    mc = 0;
    acc_cnt = 0;
    pulse_cnt = 0;
    tot_pulse = 0;
    fd_cnt = 0;
    first_at = 0;
    last_flat = '0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_win", pack(), 200'(0));
    chk("rst_pulse", 200'({valid_out_buf, frame_done}), 200'(0));
    rst_n = 1'b1;

    // 1: one frame, continuous
    send_pixels(8'h00, 784, 1'b0);
    check_frame1("c1");

    // 2: same frame, random valid duty
    fd_cnt = 0;
    send_pixels(8'h00, 784, 1'b1);
    check_frame1("c2");

    // 3: two frames back to back, frame 2 all negative
    fd_cnt = 0;
    send_pixels(8'h00, 784, 1'b0);
    check_frame1("c3a");
    fd_cnt = 0;
    send_pixels(8'h80, 784, 1'b0);
    chk("c3b_npulse", 200'(pulse_cnt), 200'(576));
    chk("c3b_ndone", 200'(fd_cnt), 200'(1));
    chk("c3b_f_d0", 200'(first0), 200'(8'h80));
    chk("c3b_f_d24", 200'(first24), 200'(8'hF4));

    // 4: abort at (10,7) with a new sof, then full frame
    fd_cnt = 0;
    send_pixels(8'h00, 10 * 28 + 7, 1'b0);
    chk("c4_abort_done", 200'(fd_cnt), 200'(0));
    send_pixels(8'h00, 784, 1'b0);
    check_frame1("c4");

    // 5: asynchronous reset mid-row 15
    send_pixels(8'h00, 15 * 28 + 10, 1'b0);
    in_valid = 1'b0;
    in_sof = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("c5_rst_win", pack(), 200'(0));
    chk("c5_rst_pulse", 200'({valid_out_buf, frame_done}), 200'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mr = 0;
    mc = 0;
    last_flat = '0;
    fd_cnt = 0;
    send_pixels(8'h00, 784, 1'b0);
    check_frame1("c5");

    // 6: sof on every cycle
    fd_cnt = 0;
    tot_pulse = 0;
    for (int n = 0; n < 200; n++) step(1'b1, 1'b1, 8'(n));
    chk("c6_npulse", 200'(tot_pulse), 200'(0));
    chk("c6_ndone", 200'(fd_cnt), 200'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
